// File: rtl/csmulti_accumulator_pkg.sv
// Shared types and helpers for the carry-save multiplier accumulator stage.
package csmulti_pkg;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } acc_state_t;

  // Batch counter width; a one-product batch still gets a 1-bit counter.
  function automatic int cnt_width(input int len);
    int w;
    w = $clog2(len);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/csmulti_accumulator_if.sv
// Product-in / batch-sum-out handshake bundle for csmulti_accumulator.
interface csmulti_accumulator_if #(
  parameter int BITSIZE = 8,
  parameter int ACC_W   = 24,
  parameter int LEN     = 4
);
  localparam int CNT_W = csmulti_pkg::cnt_width(LEN);

  logic [2*BITSIZE-1:0] prod_i;
  logic                 prod_valid_i;
  logic                 prod_ready_o;
  logic                 clear_i;
  logic [ACC_W-1:0]     acc_o;
  logic                 acc_valid_o;
  logic                 acc_ready_i;
  logic [CNT_W-1:0]     count_o;
  logic                 overflow_o;

  modport slave (
    input  prod_i, prod_valid_i, clear_i, acc_ready_i,
    output prod_ready_o, acc_o, acc_valid_o, count_o, overflow_o
  );

  modport master (
    output prod_i, prod_valid_i, clear_i, acc_ready_i,
    input  prod_ready_o, acc_o, acc_valid_o, count_o, overflow_o
  );

endinterface

// File: rtl/csmulti_accumulator_adder.sv
// ACC_W accumulator adder with carry-out; clamps to all-ones on carry when
// CSMULTI_ACC_SATURATE_EN is defined, otherwise wraps.
module csmulti_acc_adder #(
  parameter int ACC_W  = 24,
  parameter int PROD_W = 16
) (
  input  logic [ACC_W-1:0]  acc,
  input  logic [PROD_W-1:0] prod,
  output logic [ACC_W-1:0]  sum,
  output logic              carry
);

  logic [ACC_W:0] raw;

  assign raw   = {1'b0, acc} + (ACC_W+1)'(prod);
  assign carry = raw[ACC_W];

`ifdef CSMULTI_ACC_SATURATE_EN
  // Once clamped, any nonzero add carries again, so the sum stays pinned.
  assign sum = carry ? {ACC_W{1'b1}} : raw[ACC_W-1:0];
`else
  assign sum = raw[ACC_W-1:0];
`endif

endmodule

// File: rtl/csmulti_accumulator.sv
// Sums LEN consecutive multiplier products and presents each batch sum with a
// sticky overflow flag. Saturation option: CSMULTI_ACC_SATURATE_EN.
//
//  state | meaning
//  ACCUM | accepting products, building the batch sum
//  HOLD  | batch sum on acc_o, waiting for acc_ready_i
module csmulti_accumulator
  import csmulti_pkg::*;
#(
  parameter int BITSIZE = 8,
  parameter int ACC_W   = 24,
  parameter int LEN     = 4
) (
  input logic                 clk,
  input logic                 rst_n,
  csmulti_accumulator_if.slave bus
);

  localparam int PROD_W = 2 * BITSIZE;
  localparam int CNT_W  = cnt_width(LEN);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LEN - 1);

  if (ACC_W < 2 * BITSIZE) begin : g_bad_acc_w
    $error("csmulti_accumulator: ACC_W must be >= 2*BITSIZE");
  end
  if (LEN < 1) begin : g_bad_len
    $error("csmulti_accumulator: LEN must be >= 1");
  end

  acc_state_t       state;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] acc_out;
  logic [CNT_W-1:0] count;
  logic             acc_valid;
  logic             overflow;
  logic             prod_ready;

  logic [ACC_W-1:0] sum;
  logic             carry;
  logic             prod_hs;

  csmulti_acc_adder #(
    .ACC_W (ACC_W),
    .PROD_W(PROD_W)
  ) u_adder (
    .acc  (acc),
    .prod (bus.prod_i),
    .sum  (sum),
    .carry(carry)
  );

  assign prod_hs = bus.prod_valid_i & prod_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ACCUM;
      acc        <= '0;
      acc_out    <= '0;
      count      <= '0;
      acc_valid  <= 1'b0;
      overflow   <= 1'b0;
      prod_ready <= 1'b1;
    end else if (bus.clear_i) begin
      // Abort wins over both handshakes; a product offered now is dropped.
      state      <= ACCUM;
      acc        <= '0;
      count      <= '0;
      acc_valid  <= 1'b0;
      overflow   <= 1'b0;
      prod_ready <= 1'b1;
    end else begin
      case (state)
        ACCUM: begin
          if (prod_hs) begin
            if (carry) overflow <= 1'b1;
            if (count == LAST_CNT) begin
              acc_out    <= sum;
              acc_valid  <= 1'b1;
              acc        <= '0;
              count      <= '0;
              prod_ready <= 1'b0;
              state      <= HOLD;
            end else begin
              acc   <= sum;
              count <= count + 1'b1;
            end
          end
        end
        HOLD: begin
          if (bus.acc_ready_i) begin
            acc_valid  <= 1'b0;
            overflow   <= 1'b0;
            prod_ready <= 1'b1;
            state      <= ACCUM;
          end
        end
        default: state <= ACCUM;
      endcase
    end
  end

  assign bus.prod_ready_o = prod_ready;
  assign bus.acc_o        = acc_out;
  assign bus.acc_valid_o  = acc_valid;
  assign bus.count_o      = count;
  assign bus.overflow_o   = overflow;

endmodule
